// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX and RX datapaths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_OVERSAMPLE_DEF = 16;

  // PARITY is only reachable when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Even parity of a data byte; equals the XOR of all bits.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: counts b_tick pulses and flags the last tick of
// each bit time. A synchronous clear holds it at zero and masks bit_end, so a
// tick arriving on the cycle of a state entry is never counted.
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic b_tick,
  output logic bit_end
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] cnt_q;

  // Final tick of the current bit time; combinational so the FSM can act on it.
  assign bit_end = b_tick && !clr && (cnt_q == TICK_LAST);

  // Tick counter; wraps only at the end of a bit time.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (b_tick) begin
      if (cnt_q == TICK_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + TICK_W'(1);
      end
    end
  end

endmodule : uart_bit_timer

// File: rtl/uart_tx_fifo_rd.sv
// UART transmitter draining the TX byte FIFO. Pops a byte whenever the line is
// idle and the FIFO is non-empty, then sends it as 8N1 (or 8N2) LSB first,
// paced by the external oversampling baud tick.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit(s).
module uart_tx_fifo_rd
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BIT_CNT_W = 3;
  // Index of the final stop bit; anything other than 2 behaves as 1.
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

  uart_tx_state_e              state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                        tx_q, tx_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        timer_clr;
  logic                        bit_end;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif

  // Bit-time pacing; held clear in IDLE so counting starts after START entry.
  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .b_tick  (b_tick),
    .bit_end (bit_end)
  );

  // Pop strobe decoded from state; suppressed while reset is asserted.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty && !reset;

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  // Next-state and next-output logic; tx/busy/done are the values for the
  // cycle after the coming edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    timer_clr = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        busy_d    = 1'b0;
        if (!fifo_empty) begin
          shift_d   = fifo_rdata;
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = uart_even_parity(fifo_rdata);
`endif
        end
      end

      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
          tx_d      = 1'b1;
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule : uart_tx_fifo_rd

// File: tb/tb_uart_tx_fifo_rd.sv
// Self-checking bench for uart_tx_fifo_rd: a frame-level reference model checked
// every cycle, plus hand-computed frame/timing expectations.
module tb_uart_tx_fifo_rd;

  localparam int unsigned OS   = 16;
  localparam int          HIST = 8192;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
  localparam logic [11:0] F_A5 = 12'h54A;
  localparam logic [11:0] F_00 = 12'h400;
  localparam logic [11:0] F_FF = 12'h5FE;
  localparam logic [11:0] F_3C = 12'h478;
`else
  localparam int unsigned FRAME_BITS = 10;
  localparam logic [11:0] F_A5 = 12'h34A;
  localparam logic [11:0] F_00 = 12'h200;
  localparam logic [11:0] F_FF = 12'h3FE;
  localparam logic [11:0] F_3C = 12'h278;
`endif

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       b_tick     = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_rd #(
    .OVERSAMPLE (OS),
    .STOP_BITS  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .b_tick     (b_tick),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  int  tick_div = 1;
  int  drv_cyc  = 0;
  bit  pop_now  = 1'b0;

  // Monitors
  int  ncyc      = 0;
  int  pop_cnt   = 0;
  int  done_cnt  = 0;
  int  pop_cyc[$];
  int  done_cyc[$];
  int  start_cyc[$];
  logic txh [0:HIST-1];
  logic prev_tx  = 1'b1;
  bit  idle_win  = 1'b0;
  int  idle_viol = 0;

  // Reference model
  bit          m_valid  = 1'b0;
  bit          m_active = 1'b0;
  logic [11:0] m_frame  = '1;
  int          m_ticks  = 0;
  logic        e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_pop = 1'b0;

  function automatic logic [11:0] build_frame(input logic [7:0] b);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // FIFO and baud-tick driver: inputs change 1 time unit after each edge.
  initial begin
    forever begin
      @(posedge clk);
      if (pop_now && fq.size() > 0) void'(fq.pop_front());
      #1;
      drv_cyc++;
      b_tick     = (tick_div <= 1) || (drv_cyc % tick_div == 0);
      fifo_empty = (fq.size() == 0);
      fifo_rdata = fifo_empty ? 8'h00 : fq[0];
    end
  end

  // Per-cycle compare against the model, monitors, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      e_pop = m_valid && !m_active && !fifo_empty && !reset;
      if (m_valid) begin
        tests++;
        if ({tx, tx_busy, tx_done, fifo_pop} !== {e_tx, e_busy, e_done, e_pop}) begin
          fails++;
          $display("FAIL cycle_check cyc=%0d tx/busy/done/pop got %b%b%b%b expected %b%b%b%b",
                   ncyc, tx, tx_busy, tx_done, fifo_pop, e_tx, e_busy, e_done, e_pop);
        end
      end

      pop_now = (fifo_pop === 1'b1);
      if (pop_now) begin
        pop_cnt++;
        pop_cyc.push_back(ncyc);
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_cyc.push_back(ncyc);
      end
      if (prev_tx === 1'b1 && tx === 1'b0) start_cyc.push_back(ncyc);
      prev_tx = tx;
      if (ncyc < HIST) txh[ncyc] = tx;
      if (idle_win && (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_pop !== 1'b0)) idle_viol++;

      if (reset) begin
        m_valid  = 1'b1;
        m_active = 1'b0;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else if (!m_active) begin
        e_done = 1'b0;
        if (!fifo_empty) begin
          m_frame  = build_frame(fifo_rdata);
          m_ticks  = 0;
          m_active = 1'b1;
          e_tx = 1'b0; e_busy = 1'b1;
        end else begin
          e_tx = 1'b1; e_busy = 1'b0;
        end
      end else begin
        e_done = 1'b0;
        if (b_tick) m_ticks++;
        if (m_ticks == int'(FRAME_BITS * OS)) begin
          m_active = 1'b0;
          e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b1;
        end else begin
          e_tx = m_frame[m_ticks / OS]; e_busy = 1'b1;
        end
      end
      ncyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    #1;
    fq.push_back(b);
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk);
    #2;
    reset = v;
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt < target) begin
      fails++;
      $display("FAIL %s timeout got %0d tx_done pulses required %0d", name, done_cnt, target);
    end
  endtask

  // Rebuilds a frame from the tx history, referenced to the tx_done cycle.
  task automatic decode(input int d, input int bitc, output logic [11:0] f);
    int idx;
    f = '0;
    for (int j = 0; j < int'(FRAME_BITS); j++) begin
      idx = d - bitc * (int'(FRAME_BITS) - j) + bitc / 2;
      if (idx >= 0 && idx < HIST) f[j] = txh[idx];
      else f[j] = 1'bx;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, s0;
    logic [11:0] f;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_pop", fifo_pop, 0);
    set_reset(1'b0);

    // Idle with empty FIFO, tick every cycle
    @(negedge clk);
    idle_win = 1'b1;
    repeat (1000) @(negedge clk);
    idle_win = 1'b0;
    chk("idle_violations", idle_viol, 0);
    chk("idle_pops", pop_cnt, 0);

    // Single byte 0xA5
    p0 = pop_cnt; d0 = done_cnt; s0 = start_cyc.size();
    push(8'hA5);
    wait_dones(d0 + 1, 400, "a5_done");
    chk("a5_pops", pop_cnt, p0 + 1);
    if (done_cyc.size() > d0 && start_cyc.size() > s0 && pop_cyc.size() > p0) begin
      chk("a5_pop_to_start", start_cyc[s0] - pop_cyc[p0], 1);
      chk("a5_frame_len", done_cyc[d0] - start_cyc[s0], FRAME_BITS * OS);
      decode(done_cyc[d0], OS, f);
      chk("a5_frame_bits", f, F_A5);
    end

    // Back-to-back 0x00, 0xFF
    p0 = pop_cnt; d0 = done_cnt; s0 = start_cyc.size();
    @(negedge clk);
    #1;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    wait_dones(d0 + 2, 800, "b2b_done");
    chk("b2b_pops", pop_cnt, p0 + 2);
    if (pop_cyc.size() > p0 + 1 && done_cyc.size() > d0 + 1 && start_cyc.size() > s0 + 1) begin
      chk("b2b_pop_spacing", pop_cyc[p0 + 1] - pop_cyc[p0], FRAME_BITS * OS + 1);
      chk("b2b_stop_to_start", start_cyc[s0 + 1] - done_cyc[d0], 1);
      decode(done_cyc[d0], OS, f);
      chk("b2b_frame0", f, F_00);
      decode(done_cyc[d0 + 1], OS, f);
      chk("b2b_frame1", f, F_FF);
    end

    // Sparse tick: one b_tick every 7 cycles, byte 0x3C
    tick_div = 7;
    p0 = pop_cnt; d0 = done_cnt;
    push(8'h3C);
    wait_dones(d0 + 1, 2000, "sparse_done");
    chk("sparse_pops", pop_cnt, p0 + 1);
    if (done_cyc.size() > d0) begin
      decode(done_cyc[d0], 7 * OS, f);
      chk("sparse_frame_bits", f, F_3C);
    end
    tick_div = 1;
    repeat (4) @(negedge clk);

    // Reset during data bit 4 of 0x81
    p0 = pop_cnt; d0 = done_cnt; s0 = start_cyc.size();
    push(8'h81);
    begin
      int k;
      k = 0;
      while (start_cyc.size() <= s0 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rst_frame_started", start_cyc.size(), s0 + 1);
    if (start_cyc.size() > s0) begin
      while (ncyc < start_cyc[s0] + 5 * OS + 6) @(negedge clk);
      set_reset(1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("rst_tx_high", tx, 1);
      chk("rst_busy_low", tx_busy, 0);
      chk("rst_no_done", tx_done, 0);
      chk("rst_no_pop", fifo_pop, 0);
      set_reset(1'b0);
      repeat (300) @(negedge clk);
      chk("rst_done_count", done_cnt, d0);
      chk("rst_pop_count", pop_cnt, p0 + 1);
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit values
    d0 = done_cnt; s0 = start_cyc.size();
    push(8'h07);
    wait_dones(d0 + 1, 400, "par07_done");
    if (done_cyc.size() > d0 && start_cyc.size() > s0) begin
      chk("par07_frame_len", done_cyc[d0] - start_cyc[s0], 176);
      decode(done_cyc[d0], OS, f);
      chk("par07_frame_bits", f, 12'h60E);
    end
    d0 = done_cnt;
    push(8'h03);
    wait_dones(d0 + 1, 400, "par03_done");
    if (done_cyc.size() > d0) begin
      decode(done_cyc[d0], OS, f);
      chk("par03_frame_bits", f, 12'h406);
    end
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_tx_fifo_rd

// File: doc/uart_tx_fifo_rd.md
# uart_tx_fifo_rd

UART transmitter that drains the TX byte FIFO from its read side. Pops one byte whenever the FIFO is non-empty and the line is idle, then serialises it as an 8N1 frame (8 data bits, no parity, 1 stop bit) on `tx`, paced by the shared oversampling baud tick. Sits between the TX `fifo_ram`/FIFO controller pair and the UART pin in the AXI UART IP.

## Interface
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit time.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `b_tick` input, 1 bit: oversampling tick, single-cycle pulse.
- `fifo_empty` input, 1 bit: TX FIFO empty flag.
- `fifo_rdata` input, 8 bits: FIFO head byte; combinational, valid while `fifo_empty`=0.
- `fifo_pop` output, 1 bit: single-cycle pop strobe.
- `tx` output, 1 bit: serial line; idles high.
- `tx_busy` output, 1 bit: high in every state except IDLE.
- `tx_done` output, 1 bit: one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE, START, DATA, STOP (PARITY is added when `UART_TX_PARITY_EN` is defined).
- IDLE:
  - `tx`=1.
  - If `fifo_empty`=0: assert `fifo_pop` for this cycle, latch `fifo_rdata` into the shift register on the same edge, clear the tick counter, go to START.
  - `b_tick` is ignored.
- START:
  - `tx`=0.
  - Count `b_tick`; on the OVERSAMPLE-th tick clear the counter, clear the bit counter, go to DATA.
- DATA:
  - `tx` = shift register bit 0, sent LSB first.
  - Every OVERSAMPLE ticks: shift right one bit, increment the bit counter.
  - After bit 7 completes, go to STOP (or PARITY).
- STOP:
  - `tx`=1 for STOP_BITS×OVERSAMPLE ticks.
  - Then pulse `tx_done` and go to IDLE.
- `fifo_pop` is never asserted while `fifo_empty`=1 and never asserted outside IDLE.
- Tick counter width is $clog2(OVERSAMPLE); bit counter is 3 bits. Neither counter wraps mid-bit.
- All outputs are registered except `fifo_pop`, which is decoded from state and `fifo_empty`.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `fifo_pop`=0, state IDLE, both counters 0.
- Latency: `tx` falls on the edge after the pop cycle.
- Frame length: exactly (10 + STOP_BITS − 1)×OVERSAMPLE ticks.
- Back-to-back frames: `tx_done` and the return to IDLE happen on the same edge. If the FIFO is non-empty, the pop happens in the next cycle. The gap between stop end and the next start is therefore one clock, with no idle bit time.
- Reset asserted mid-frame: on the next edge `tx`=1, state IDLE, no `tx_done`, no pop. The partially sent byte is lost and the FIFO is not re-read.
- `b_tick` on the same cycle as a state transition into a counting state is not counted. Counting begins on the first tick after entry.
- `fifo_empty` dropping in the same cycle as `tx_done` has no effect until IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even parity of the data byte (XOR of the 8 bits) for OVERSAMPLE ticks.
  - Frame length grows by one bit time.
- `UART_TX_PARITY_EN` undefined: no PARITY state, plain 8N1/8N2.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_tx_state_e` enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_OVERSAMPLE_DEF` = 16.
- One sub-module, `uart_bit_timer`: tick counter with a `bit_end` pulse output and a synchronous clear. It is reused by the RX side.
- The shift register and FSM stay in `uart_tx_fifo_rd`. The baud tick generator is external.

## Test plan
- Reset then idle: `fifo_empty`=1 for 1000 cycles, `b_tick` every cycle → `tx`=1, `fifo_pop`=0, `tx_busy`=0 throughout.
- Single byte: FIFO holds 0xA5, `b_tick` every cycle →
  - exactly one pop;
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles;
  - `tx_done` pulses at cycle 160 after start;
  - `tx_busy` falls with it.
- Back-to-back: FIFO holds 0x00, 0xFF →
  - two pops exactly 161 cycles apart;
  - the second start bit begins one clock after the first stop ends.
- Sparse tick: `b_tick` every 7 cycles, byte 0x3C → each bit lasts 16 ticks = 112 cycles; bits decode to 0x3C.
- Reset mid-DATA: assert `reset` at bit 4 of 0x81 →
  - `tx`=1 on the next edge;
  - no `tx_done`;
  - the FIFO is popped only once in total until new data arrives.
- `UART_TX_PARITY_EN` defined: byte 0x07 → parity bit 1, frame 11 bits = 176 ticks; byte 0x03 → parity bit 0.
